m_dm_access: RTL and testbench

- M-stage data-memory access controller. It sits directly upstream of the W-stage load extender.
- Takes the M-stage memory op, address and store data, and generates byte enables and lane-replicated write data.
- Runs a req/ack handshake to a variable-latency data memory and stalls the pipeline until the access completes.
- Registers the raw read word, the address low bits and the op into the W stage, which performs sign/zero extension.

---
 rtl/m_dm_access.sv | 146 ++++++++++++++
 tb/tb_m_dm_access.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dm_access.sv
// M-stage data-memory access controller: byte enables, lane-replicated store data,
// req/ack handshake with pipeline stall, and W-stage capture. Optional macro: DM_ADDR_EXC_EN.
module m_dm_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_M,
  input  logic [3:0]        DM_Op_M,
  input  logic [ADDR_W-1:0] Addr_M,
  input  logic [31:0]       WData_M,
  output logic              stall_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        DM_Op_W,
  output logic [1:0]        A_W,
  output logic [31:0]       RData_W,
  output logic              exc_W
);

  // state | meaning
  // IDLE  | no access outstanding; M-stage op is decoded and issued or passed to W
  // WAIT  | request outstanding; M frozen until mem_ack
  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  a_q;
  logic [1:0]  a_m;
  logic        is_mem;
  logic        misalign;
  logic        issue;
  logic [3:0]  byteen_d;
  logic [31:0] wdata_d;

  assign a_m    = Addr_M[1:0];
  assign is_mem = valid_M && (DM_Op_M >= 4'd1) && (DM_Op_M <= 4'd6);

`ifdef DM_ADDR_EXC_EN
  always_comb begin
    misalign = 1'b0;
    case (DM_Op_M)
      4'd2, 4'd5: misalign = is_mem && a_m[0];
      4'd3, 4'd6: misalign = is_mem && (a_m != 2'd0);
      default:    misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign issue   = (state == IDLE) && is_mem && !misalign;
  assign stall_M = issue || ((state == WAIT) && !mem_ack);

  always_comb begin
    byteen_d = 4'b0000;
    wdata_d  = 32'd0;
    case (DM_Op_M)
      4'd1: begin
        byteen_d = 4'b0001 << a_m;
        wdata_d  = {4{WData_M[7:0]}};
      end
      4'd2: begin
        byteen_d = a_m[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{WData_M[15:0]}};
      end
      4'd3: begin
        byteen_d = 4'b1111;
        wdata_d  = WData_M;
      end
      default: begin
        byteen_d = 4'b0000;
        wdata_d  = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_byteen <= 4'b0000;
      mem_wdata  <= 32'd0;
      op_q       <= 4'd0;
      a_q        <= 2'd0;
      DM_Op_W    <= 4'd0;
      A_W        <= 2'd0;
      RData_W    <= 32'd0;
      exc_W      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= WAIT;
            mem_req    <= 1'b1;
            mem_we     <= (DM_Op_M <= 4'd3);
            mem_addr   <= {Addr_M[ADDR_W-1:2], 2'b00};
            mem_byteen <= byteen_d;
            mem_wdata  <= wdata_d;
            op_q       <= DM_Op_M;
            a_q        <= a_m;
            DM_Op_W    <= 4'd0;
            A_W        <= 2'd0;
            RData_W    <= 32'd0;
            exc_W      <= 1'b0;
          end else if (misalign) begin
            DM_Op_W <= 4'd0;
            A_W     <= a_m;
            RData_W <= 32'd0;
            exc_W   <= 1'b1;
          end else begin
            DM_Op_W <= valid_M ? DM_Op_M : 4'd0;
            A_W     <= a_m;
            RData_W <= 32'd0;
            exc_W   <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            DM_Op_W <= op_q;
            A_W     <= a_q;
            RData_W <= (op_q >= 4'd4) ? mem_rdata : 32'd0;
            exc_W   <= 1'b0;
          end else begin
            // stalled cycle: W sees a bubble so the instruction is not duplicated
            DM_Op_W <= 4'd0;
            A_W     <= 2'd0;
            RData_W <= 32'd0;
            exc_W   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_dm_access.sv
// Randomized bench for m_dm_access against a transaction-level model, plus directed literal cases.
module tb_m_dm_access;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_M;
  logic [3:0]        DM_Op_M;
  logic [ADDR_W-1:0] Addr_M;
  logic [31:0]       WData_M;
  logic              stall_M, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byteen;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [3:0]        DM_Op_W;
  logic [1:0]        A_W;
  logic [31:0]       RData_W;
  logic              exc_W;

  int total = 0;
  int bad   = 0;

  m_dm_access #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .DM_Op_M(DM_Op_M), .Addr_M(Addr_M),
    .WData_M(WData_M), .stall_M(stall_M), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .DM_Op_W(DM_Op_W), .A_W(A_W),
    .RData_W(RData_W), .exc_W(exc_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_mem_f(input logic v, input logic [3:0] op);
    return v && (op inside {[4'd1:4'd6]});
  endfunction

  function automatic logic mis_f(input logic v, input logic [3:0] op, input logic [1:0] a);
`ifdef DM_ADDR_EXC_EN
    if (!is_mem_f(v, op)) return 1'b0;
    if (op == 4'd2 || op == 4'd5) return a[0];
    if (op == 4'd3 || op == 4'd6) return a != 2'd0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] be_f(input logic [3:0] op, input logic [1:0] a);
    if (op == 4'd1) return 4'(1 << a);
    if (op == 4'd2) return (a >= 2) ? 4'hC : 4'h3;
    if (op == 4'd3) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] wd_f(input logic [3:0] op, input logic [31:0] wd);
    if (op == 4'd1) return wd[7:0] * 32'h01010101;
    if (op == 4'd2) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  // transaction-level reference: one outstanding access plus the expected W contents
  logic              m_busy;
  logic [3:0]        p_op;
  logic [1:0]        p_a;
  logic              e_req, e_we, e_exc;
  logic [ADDR_W-1:0] e_addr;
  logic [3:0]        e_be, e_opw;
  logic [31:0]       e_wd, e_rd;
  logic [1:0]        e_aw;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; p_op <= 0; p_a <= 0;
      e_req <= 0; e_we <= 0; e_addr <= 0; e_be <= 0; e_wd <= 0;
      e_opw <= 0; e_aw <= 0; e_rd <= 0; e_exc <= 0;
    end else if (!m_busy) begin
      if (is_mem_f(valid_M, DM_Op_M) && !mis_f(valid_M, DM_Op_M, Addr_M[1:0])) begin
        m_busy <= 1; p_op <= DM_Op_M; p_a <= Addr_M[1:0];
        e_req <= 1; e_we <= (DM_Op_M < 4); e_addr <= Addr_M - ADDR_W'(Addr_M % 4);
        e_be <= be_f(DM_Op_M, Addr_M[1:0]); e_wd <= wd_f(DM_Op_M, WData_M);
        e_opw <= 0; e_aw <= 0; e_rd <= 0; e_exc <= 0;
      end else if (mis_f(valid_M, DM_Op_M, Addr_M[1:0])) begin
        e_opw <= 0; e_aw <= Addr_M[1:0]; e_rd <= 0; e_exc <= 1;
      end else begin
        e_opw <= valid_M ? DM_Op_M : 4'd0; e_aw <= Addr_M[1:0]; e_rd <= 0; e_exc <= 0;
      end
    end else if (mem_ack) begin
      m_busy <= 0; e_req <= 0;
      e_opw <= p_op; e_aw <= p_a; e_rd <= (p_op >= 4) ? mem_rdata : 32'd0; e_exc <= 0;
    end else begin
      e_opw <= 0; e_aw <= 0; e_rd <= 0; e_exc <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("stall_M", stall_M, m_busy ? !mem_ack
          : (is_mem_f(valid_M, DM_Op_M) && !mis_f(valid_M, DM_Op_M, Addr_M[1:0])));
      if (e_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_byteen", mem_byteen, e_be);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      end
    end
    chk("mem_req", mem_req, e_req);
    chk("DM_Op_W", DM_Op_W, e_opw);
    chk("A_W", A_W, e_aw);
    chk("RData_W", RData_W, e_rd);
    chk("exc_W", exc_W, e_exc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    valid_M = v; DM_Op_M = op; Addr_M = a; WData_M = wd;
  endtask

  int stalls;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_opw", DM_Op_W, 0);
    chk("rst_rd", RData_W, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();

    // lw 0x100, three un-acked WAIT cycles then ack
    drive(1, 6, 32'h100, 0);
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
      @(negedge clk);
      if (stall_M) stalls++;
      if (i == 2) begin
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_be", mem_byteen, 4'b0000);
        chk("lw_we", mem_we, 0);
      end
      tick();
      if (i == 0) drive(1, 3, 32'h5557, 32'hFFFFFFFF);
    end
    drive(0, 0, 0, 0);
    mem_ack = 0;
    chk("lw_stalls", stalls, 4);
    chk("lw_rd", RData_W, 32'hDEADBEEF);
    chk("lw_opw", DM_Op_W, 6);
    chk("lw_aw", A_W, 0);

    // sb 0x203, immediate ack
    drive(1, 1, 32'h203, 32'h12345678);
    @(negedge clk); chk("sb_stall0", stall_M, 1);
    tick();
    drive(0, 0, 0, 0); mem_ack = 1;
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_be", mem_byteen, 4'b1000);
    chk("sb_wd", mem_wdata, 32'h78787878);
    @(negedge clk); chk("sb_stall1", stall_M, 0);
    tick();
    mem_ack = 0;
    chk("sb_opw", DM_Op_W, 1);

    // sh 0x102, then lb 0x101
    drive(1, 2, 32'h102, 32'hAAAA5555);
    tick();
    chk("sh_be", mem_byteen, 4'b1100);
    chk("sh_wd", mem_wdata, 32'h55555555);
    drive(0, 0, 0, 0); mem_ack = 1;
    tick();
    mem_ack = 0;
    drive(1, 4, 32'h101, 0);
    tick();
    drive(0, 0, 0, 0); mem_ack = 1; mem_rdata = 32'h11223344;
    tick();
    mem_ack = 0;
    chk("lb_aw", A_W, 2'b01);
    chk("lb_opw", DM_Op_W, 4);
    chk("lb_rd", RData_W, 32'h11223344);

    // non-mem op then bubble
    drive(1, 0, 32'h7, 0);
    @(negedge clk); chk("nm_stall", stall_M, 0);
    tick();
    chk("nm_req", mem_req, 0);
    chk("nm_opw", DM_Op_W, 0);
    chk("nm_aw", A_W, 3);
    drive(0, 6, 32'h100, 0);
    @(negedge clk); chk("bub_stall", stall_M, 0);
    tick();
    chk("bub_req", mem_req, 0);
    chk("bub_opw", DM_Op_W, 0);

    // reset during WAIT, then a clean lw
    drive(1, 6, 32'h300, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("rw_req1", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rw_req0", mem_req, 0);
    chk("rw_opw", DM_Op_W, 0);
    chk("rw_rd", RData_W, 0);
    drive(1, 6, 32'h400, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rw_new_req", mem_req, 1);
    chk("rw_new_addr", mem_addr, 32'h400);
    drive(0, 0, 0, 0); mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    chk("rw_new_rd", RData_W, 32'hCAFEF00D);

    // lw at 0x102
`ifdef DM_ADDR_EXC_EN
    drive(1, 6, 32'h102, 0);
    @(negedge clk); chk("exc_stall", stall_M, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("exc_req", mem_req, 0);
    chk("exc_flag", exc_W, 1);
    chk("exc_opw", DM_Op_W, 0);
    chk("exc_aw", A_W, 2);
    tick();
    chk("exc_clr", exc_W, 0);
`else
    drive(1, 6, 32'h102, 0);
    @(negedge clk); chk("mis_stall", stall_M, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("mis_req", mem_req, 1);
    chk("mis_addr", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 0;
    chk("mis_exc", exc_W, 0);
    chk("mis_opw", DM_Op_W, 6);
    chk("mis_aw", A_W, 2);
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      valid_M   = ($urandom % 5) != 0;
      DM_Op_M   = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'(1 + $urandom % 6);
      Addr_M    = $urandom;
      WData_M   = $urandom;
      mem_ack   = ($urandom % 3) == 0;
      mem_rdata = $urandom;
      if (n == 2000) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
      tick();
    end
    drive(0, 0, 0, 0);
    mem_ack = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
